avl_dmem_slave: RTL and testbench

//  Avalon-MM data-memory slave directly downstream of the core load/store adapter.

---
 rtl/avl_dmem_pkg.sv | 17 +
 rtl/avl_dmem_ram.sv | 31 +++
 rtl/avl_dmem_slave.sv | 149 ++++++++++++++
 tb/tb_avl_dmem_slave.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/avl_dmem_pkg.sv
// Shared definitions for the Avalon-MM data-memory slave: FSM encoding, lane count
// and word-index width helper.
package avl_dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BYTE_LANES = 4;

    function automatic int idx_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/avl_dmem_ram.sv
// Single-port synchronous word RAM with per-byte write enables; contents start
// undefined.
module avl_dmem_ram
    import avl_dmem_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int IDX_W     = 10,
    parameter     INIT_FILE = ""
) (
    input  logic                    clk,
    input  logic [IDX_W-1:0]        addr,
    input  logic                    we,
    input  logic [BYTE_LANES-1:0]   be,
    input  logic [8*BYTE_LANES-1:0] wdata,
    output logic [8*BYTE_LANES-1:0] rdata
);

    logic [8*BYTE_LANES-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch so it maps onto block RAM and keeps its
    // contents across a reset of the surrounding logic.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (we && be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/avl_dmem_slave.sv
// Avalon-MM data-memory slave with programmable wait states.
// Optional error flag/counter ports are added when AVL_DMEM_ERR_EN is defined.
module avl_dmem_slave
    import avl_dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0,
    parameter     INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] writedata,
    input  logic [BYTE_LANES-1:0] byteenable,
    input  logic                  read,
    input  logic                  write,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  waitrequest
`ifdef AVL_DMEM_ERR_EN
    ,
    output logic                  err,
    output logic [7:0]            err_cnt
`endif
);

    localparam int         IDX_W = idx_width(DEPTH_WORDS);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    state_t                state;
    logic [3:0]            cnt;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wd_q;
    logic [BYTE_LANES-1:0] be_q;
    logic                  wr_q;
    logic                  both_q;
    logic                  oor_q;
    logic                  drop_q;
    logic [DATA_WIDTH-1:0] rd_hold;
    logic [DATA_WIDTH-1:0] rd_now;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [IDX_W-1:0]      ram_addr;
    logic                  ram_we;
    logic                  req;
    logic                  oor_in;
    logic                  done_ok;
    logic                  unused_addr_bits;

    assign req              = read | write;
    assign oor_in           = (address >> (IDX_W + 2)) != '0;
    assign unused_addr_bits = ^address[1:0];

    // The RAM read is issued from the live address in IDLE and re-issued from the
    // latched index afterwards, so its output is valid by DONE for any wait count.
    assign ram_addr = (state == IDLE) ? address[IDX_W+1:2] : idx_q;

    // A transfer only takes effect if the master kept its request up through DONE.
    assign done_ok     = (state == DONE) && req && !drop_q;
    assign ram_we      = done_ok && wr_q && !oor_q;
    assign waitrequest = req && (state != DONE);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        rd_now = rd_hold;
        if (done_ok) begin
            if (both_q) begin
                rd_now = '0;
            end else if (!wr_q) begin
                rd_now = oor_q ? '0 : ram_q;
            end
        end
    end

    assign readdata = rd_now;

    avl_dmem_ram #(
        .DEPTH    (DEPTH_WORDS),
        .IDX_W    (IDX_W),
        .INIT_FILE(INIT_FILE)
    ) u_ram (
        .clk  (clk),
        .addr (ram_addr),
        .we   (ram_we),
        .be   (be_q),
        .wdata(wd_q),
        .rdata(ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wd_q    <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            both_q  <= 1'b0;
            oor_q   <= 1'b0;
            drop_q  <= 1'b0;
            rd_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    drop_q <= 1'b0;
                    if (req) begin
                        idx_q  <= address[IDX_W+1:2];
                        wd_q   <= writedata;
                        be_q   <= byteenable;
                        wr_q   <= write;
                        both_q <= read && write;
                        oor_q  <= oor_in;
                        cnt    <= WS;
                        state  <= (WS != 4'd0) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (!req) begin
                        drop_q <= 1'b1;
                    end
                    if (cnt == 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    rd_hold <= rd_now;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AVL_DMEM_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (done_ok && (oor_q || (wr_q && be_q == '0))) begin
            err <= 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_avl_dmem_slave.sv
// Scoreboard bench for avl_dmem_slave: one instance with 0 wait states, one with 3,
// sharing a master bus steered by sel.
module tb_avl_dmem_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wd = '0;
    logic [3:0]  bus_be = '0;
    logic        bus_rd = 1'b0;
    logic        bus_wr = 1'b0;

    logic        rd0, wr0, rd3, wr3;
    logic [31:0] rdata0, rdata3, rdata_m;
    logic        wreq0, wreq3, wreq_m;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] rd;
        int          waits;
        string       name;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    assign rd0     = bus_rd & ~sel;
    assign wr0     = bus_wr & ~sel;
    assign rd3     = bus_rd & sel;
    assign wr3     = bus_wr & sel;
    assign rdata_m = sel ? rdata3 : rdata0;
    assign wreq_m  = sel ? wreq3 : wreq0;

`ifdef AVL_DMEM_ERR_EN
    logic       err0, err3;
    logic [7:0] err_cnt0, err_cnt3;
`endif

    avl_dmem_slave #(.WAIT_STATES(0)) u_dut0 (
        .clk        (clk),
        .reset      (rst),
        .address    (bus_addr),
        .writedata  (bus_wd),
        .byteenable (bus_be),
        .read       (rd0),
        .write      (wr0),
        .readdata   (rdata0),
        .waitrequest(wreq0)
`ifdef AVL_DMEM_ERR_EN
        ,
        .err        (err0),
        .err_cnt    (err_cnt0)
`endif
    );

    avl_dmem_slave #(.WAIT_STATES(3)) u_dut3 (
        .clk        (clk),
        .reset      (rst),
        .address    (bus_addr),
        .writedata  (bus_wd),
        .byteenable (bus_be),
        .read       (rd3),
        .write      (wr3),
        .readdata   (rdata3),
        .waitrequest(wreq3)
`ifdef AVL_DMEM_ERR_EN
        ,
        .err        (err3),
        .err_cnt    (err_cnt3)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: counts stall cycles of the live request and scores each completion.
    int wcnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst || !(bus_rd || bus_wr)) begin
            wcnt = 0;
        end else if (wreq_m) begin
            wcnt++;
        end else begin
            if (sbq.size() == 0) begin
                check("unexpected_completion", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check({e.name, "_readdata"}, rdata_m, e.rd);
                check({e.name, "_waits"}, 32'(wcnt), 32'(e.waits));
            end
            wcnt = 0;
        end
    end

    task automatic access(input logic s, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic r, input logic w,
                          input logic [31:0] exp_rd, input int exp_w, input string nm);
        int n;
        sbq.push_back('{exp_rd, exp_w, nm});
        sel      = s;
        bus_addr = a;
        bus_wd   = wd;
        bus_be   = be;
        bus_rd   = r;
        bus_wr   = w;
        n = 0;
        @(negedge clk);
        while (wreq_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check({nm, "_timeout"}, 32'd1, 32'd0);
        end
        @(posedge clk);
        #1;
        bus_rd = 1'b0;
        bus_wr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        sel = 1'b0;
        #1;
        check("rst_rd0", rdata_m, 32'h0);
        check("rst_wr0", {31'd0, wreq_m}, 32'd0);
        sel = 1'b1;
        #1;
        check("rst_rd3", rdata_m, 32'h0);
        check("rst_wr3", {31'd0, wreq_m}, 32'd0);

        // Three-wait-state instance: four stall cycles per access.
        access(1'b1, 32'h0,  32'h01020304, 4'hF, 1'b0, 1'b1, 32'h0,        4, "ws3_wr0");
        access(1'b1, 32'h0,  32'h0,        4'hF, 1'b1, 1'b0, 32'h01020304, 4, "ws3_rd0");
        access(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 32'h01020304, 4, "ws3_wr20");

        // Reset lands while a write to 0x20 is in BUSY.
        sel      = 1'b1;
        bus_addr = 32'h20;
        bus_wd   = 32'h12345678;
        bus_be   = 4'hF;
        bus_wr   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        bus_wr = 1'b0;
        #1;
        check("midrst_readdata", rdata_m, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        access(1'b1, 32'h20, 32'h0, 4'hF, 1'b1, 1'b0, 32'hCAFEF00D, 4, "ws3_rd20_after_rst");

        // Write dropped during BUSY must not reach the RAM.
        bus_addr = 32'h0;
        bus_wd   = 32'h00000BAD;
        bus_be   = 4'hF;
        bus_wr   = 1'b1;
        @(posedge clk);
        #1;
        bus_wr = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        access(1'b1, 32'h0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h01020304, 4, "ws3_rd0_after_drop");

        // Zero-wait-state instance.
        access(1'b0, 32'h10,   32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h0,        1, "ws0_wr10");
        access(1'b0, 32'h10,   32'h0,        4'hF, 1'b1, 1'b0, 32'hDEADBEEF, 1, "ws0_rd10");
        access(1'b0, 32'h10,   32'h0000AA00, 4'h2, 1'b0, 1'b1, 32'hDEADBEEF, 1, "ws0_wrlane1");
        access(1'b0, 32'h10,   32'h0,        4'hF, 1'b1, 1'b0, 32'hDEADAAEF, 1, "ws0_rdlane1");
        access(1'b0, 32'h1000, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0,        1, "ws0_rd_oor");
        access(1'b0, 32'h1010, 32'h11111111, 4'hF, 1'b0, 1'b1, 32'h0,        1, "ws0_wr_oor");
        access(1'b0, 32'h10,   32'h22222222, 4'h0, 1'b0, 1'b1, 32'h0,        1, "ws0_wr_be0");
        access(1'b0, 32'h10,   32'h0,        4'hF, 1'b1, 1'b0, 32'hDEADAAEF, 1, "ws0_rd10_unchanged");
        access(1'b0, 32'h4,    32'h00000055, 4'hF, 1'b1, 1'b1, 32'h0,        1, "ws0_rdwr_both");
        access(1'b0, 32'h4,    32'h0,        4'hF, 1'b1, 1'b0, 32'h00000055, 1, "ws0_rd4");

`ifdef AVL_DMEM_ERR_EN
        check("err0", {31'd0, err0}, 32'd1);
        check("err_cnt0", {24'd0, err_cnt0}, 32'd3);
        check("err3", {31'd0, err3}, 32'd0);
        check("err_cnt3", {24'd0, err_cnt3}, 32'd0);
`endif

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
